// File: rtl/enc_pkg.sv
// Shared encoder/decoder family package: FSM encodings and default widths.
// Optional ENC_MULTI_FLAG_EN adds the one-hot violation flag on the encoder.
package enc_pkg;

  localparam int ENC_N = 8;
  localparam int ENC_W = $clog2(ENC_N);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } enc_state_e;

  function automatic logic multi_hot(
    input logic [ENC_N-1:0] v
  );
    return (v & (v - ENC_N'(1))) != '0;
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational highest-set-bit finder.
// Ascending loop lets the highest set index win.
module prio_enc_comb #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_8to3_seq.sv
// Sequential priority encoder: emits set-bit indices high to low over valid/ready.
// Define ENC_MULTI_FLAG_EN to add the 'multi' output.
module encoder_8to3_seq
  import enc_pkg::*;
#(
  parameter int N = ENC_N,
  parameter int W = ENC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [W-1:0] y,
  output logic         valid,
  input  logic         ready,
  output logic         busy,
  output logic         done,
`ifdef ENC_MULTI_FLAG_EN
  output logic         multi,
`endif
  output logic         zero
);

  enc_state_e   state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] y_q, y_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         zero_q, zero_d;
  logic         multi_d;

  logic [N-1:0] pend_clr;
  logic [N-1:0] enc_in;
  logic [W-1:0] enc_idx;
  logic         enc_any;

  // One finder serves both the fresh capture and the remaining bits.
  assign pend_clr = pend_q & ~(N'(1) << y_q);
  assign enc_in   = (state_q == ST_IDLE) ? d : pend_clr;

  prio_enc_comb #(
    .N(N),
    .W(W)
  ) u_prio (
    .req(enc_in),
    .idx(enc_idx),
    .any(enc_any)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    y_d     = y_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    zero_d  = 1'b0;
    multi_d = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      pend_d  = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load) begin
            if (enc_any) begin
              state_d = ST_BUSY;
              pend_d  = d;
              y_d     = enc_idx;
              valid_d = 1'b1;
              busy_d  = 1'b1;
              multi_d = multi_hot(d);
            end else begin
              zero_d = 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (valid_q && ready) begin
            pend_d = pend_clr;
            if (enc_any) begin
              y_d = enc_idx;
            end else begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

`ifdef ENC_MULTI_FLAG_EN
  logic multi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_q <= 1'b0;
    end else begin
      multi_q <= multi_d;
    end
  end

  assign multi = multi_q;
`else
  logic unused_multi;
  assign unused_multi = multi_d;
`endif

  assign y     = y_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign zero  = zero_q;

endmodule
